// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Fetch entries and default reset/NOP values.
package riscv_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT    = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTRUCTION_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCREMENT            = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(
    input logic [XLEN-1:0] addr
  );
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries.
// Flush clears occupancy and pointers in one cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fetch_entry_t  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; head is masked upstream while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, queues cache data,
// hands {pc, instruction} to decode, applies redirects.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = RESET_VECTOR_DEFAULT,
  parameter int          QUEUE_DEPTH     = 2,
  parameter logic [31:0] NOP_INSTRUCTION = NOP_INSTRUCTION_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] PC,
  output logic        INSTRUCTION_CACHE_STALL,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTRUCTION_CACHE_READY,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        DECODE_STALL,
  output logic        ID_VALID,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_INSTRUCTION
);

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [31:0]  pc_q;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Redirect wins over both queue events.
  assign push = INSTRUCTION_CACHE_READY && !full && !BRANCH_TAKEN;
  assign pop  = !empty && !DECODE_STALL && !BRANCH_TAKEN;

  assign wr_entry.pc          = pc_q;
  assign wr_entry.instruction = INSTRUCTION;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q <= RESET_VECTOR;
    end else if (BRANCH_TAKEN) begin
      pc_q <= align_word(BRANCH_TARGET);
    end else if (push) begin
      pc_q <= pc_q + PC_INCREMENT;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .push     (push),
    .pop      (pop),
    .flush    (BRANCH_TAKEN),
    .wr_entry (wr_entry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign PC                      = pc_q;
  assign INSTRUCTION_CACHE_STALL = full;
  assign ID_VALID                = empty ? LOW : HIGH;
  assign ID_PC                   = empty ? '0 : head.pc;
  assign ID_INSTRUCTION          = empty ? NOP_INSTRUCTION
                                         : head.instruction;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit.
// Directed tests; a negedge monitor checks decode hand-offs.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] PC;
  logic        STALL;
  logic [31:0] INSTRUCTION;
  logic        READY;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        DECODE_STALL;
  logic        ID_VALID;
  logic [31:0] ID_PC;
  logic [31:0] ID_INSTRUCTION;

  logic        w_rst_n;
  logic [31:0] w_pc;
  logic        w_stall;
  logic [31:0] w_instr;
  logic        w_ready;
  logic        w_branch;
  logic [31:0] w_target;
  logic        w_dstall;
  logic        w_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_instr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] exp_w [$];
  logic [31:0] mon_e;
  logic [31:0] mon_we;
  logic [31:0] pc_model;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign INSTRUCTION = inst_of(PC);
  assign w_instr     = inst_of(w_pc);

  instruction_fetch_unit dut (
    .CLK                     (CLK),
    .RESET_N                 (RESET_N),
    .PC                      (PC),
    .INSTRUCTION_CACHE_STALL (STALL),
    .INSTRUCTION             (INSTRUCTION),
    .INSTRUCTION_CACHE_READY (READY),
    .BRANCH_TAKEN            (BRANCH_TAKEN),
    .BRANCH_TARGET           (BRANCH_TARGET),
    .DECODE_STALL            (DECODE_STALL),
    .ID_VALID                (ID_VALID),
    .ID_PC                   (ID_PC),
    .ID_INSTRUCTION          (ID_INSTRUCTION)
  );

  instruction_fetch_unit #(
    .RESET_VECTOR (32'hFFFF_FFF8)
  ) dut_w (
    .CLK                     (CLK),
    .RESET_N                 (w_rst_n),
    .PC                      (w_pc),
    .INSTRUCTION_CACHE_STALL (w_stall),
    .INSTRUCTION             (w_instr),
    .INSTRUCTION_CACHE_READY (w_ready),
    .BRANCH_TAKEN            (w_branch),
    .BRANCH_TARGET           (w_target),
    .DECODE_STALL            (w_dstall),
    .ID_VALID                (w_valid),
    .ID_PC                   (w_id_pc),
    .ID_INSTRUCTION          (w_id_instr)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    tick();
    RESET_N       = 1'b0;
    READY         = 1'b0;
    DECODE_STALL  = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = '0;
    exp_q.delete();
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  // A delivery happens whenever decode takes the head this cycle.
  always @(negedge CLK) begin
    if (ID_VALID && !DECODE_STALL && !BRANCH_TAKEN) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual=%h required=none",
                 ID_PC);
      end else begin
        mon_e = exp_q.pop_front();
        chk("id_pc", ID_PC, mon_e);
        chk("id_instr", ID_INSTRUCTION, inst_of(mon_e));
      end
    end
  end

  always @(negedge CLK) begin
    if (w_valid && !w_dstall && !w_branch) begin
      if (exp_w.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected_delivery actual=%h required=none",
                 w_id_pc);
      end else begin
        mon_we = exp_w.pop_front();
        chk("w_id_pc", w_id_pc, mon_we);
        chk("w_id_instr", w_id_instr, inst_of(mon_we));
      end
    end
  end

  initial begin
    RESET_N       = 1'b0;
    READY         = 1'b0;
    DECODE_STALL  = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = '0;
    w_rst_n       = 1'b0;
    w_ready       = 1'b1;
    w_branch      = 1'b0;
    w_target      = '0;
    w_dstall      = 1'b0;

    tick();
    tick();
    at_neg();
    chk("rst_valid", {31'd0, ID_VALID}, 32'd0);
    chk("rst_id_pc", ID_PC, 32'd0);
    chk("rst_id_instr", ID_INSTRUCTION, 32'h0000_0013);
    chk("rst_stall", {31'd0, STALL}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("w_rst_pc", w_pc, 32'hFFFF_FFF8);
    chk("w_rst_valid", {31'd0, w_valid}, 32'd0);

    // Streaming from reset
    do_reset();
    READY = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    at_neg();
    chk("t1_pc0", PC, 32'h0);
    chk("t1_valid0", {31'd0, ID_VALID}, 32'd0);
    tick();
    at_neg();
    chk("t1_valid1", {31'd0, ID_VALID}, 32'd1);
    chk("t1_pc1", PC, 32'h4);
    tick();
    tick();
    tick();
    READY = 1'b0;
    at_neg();
    tick();
    at_neg();
    chk("t1_drained", {31'd0, ID_VALID}, 32'd0);
    chk("t1_pc_hold", PC, 32'h10);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Decode stall fills the queue
    do_reset();
    READY = 1'b1;
    DECODE_STALL = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    tick();
    at_neg();
    chk("t2_full_stall", {31'd0, STALL}, 32'd1);
    chk("t2_full_pc", PC, 32'h8);
    tick();
    tick();
    tick();
    chk("t2_held_pc", PC, 32'h8);
    DECODE_STALL = 1'b0;
    at_neg();
    chk("t2_stall_before_pop", {31'd0, STALL}, 32'd1);
    tick();
    READY = 1'b0;
    at_neg();
    chk("t2_stall_after_pop", {31'd0, STALL}, 32'd0);
    chk("t2_pc_after_pop", PC, 32'h8);
    tick();
    at_neg();
    chk("t2_drained", {31'd0, ID_VALID}, 32'd0);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Redirect with a full queue
    do_reset();
    READY = 1'b1;
    DECODE_STALL = 1'b1;
    tick();
    tick();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h0000_0102;
    at_neg();
    chk("t3_full_before", {31'd0, STALL}, 32'd1);
    tick();
    BRANCH_TAKEN = 1'b0;
    DECODE_STALL = 1'b0;
    exp_q.push_back(32'h100);
    at_neg();
    chk("t3_valid_after", {31'd0, ID_VALID}, 32'd0);
    chk("t3_stall_after", {31'd0, STALL}, 32'd0);
    chk("t3_pc_target", PC, 32'h100);
    tick();
    READY = 1'b0;
    at_neg();
    chk("t3_pc_next", PC, 32'h104);
    tick();
    at_neg();
    chk("t3_drained", {31'd0, ID_VALID}, 32'd0);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // PC wrap on the second instance
    tick();
    w_rst_n = 1'b1;
    exp_w.push_back(32'hFFFF_FFF8);
    exp_w.push_back(32'hFFFF_FFFC);
    exp_w.push_back(32'h0000_0000);
    at_neg();
    chk("t4_pc0", w_pc, 32'hFFFF_FFF8);
    tick();
    at_neg();
    chk("t4_pc1", w_pc, 32'hFFFF_FFFC);
    tick();
    at_neg();
    chk("t4_pc2", w_pc, 32'h0000_0000);
    tick();
    w_ready = 1'b0;
    at_neg();
    chk("t4_pc3", w_pc, 32'h0000_0004);
    tick();
    at_neg();
    chk("t4_drained", {31'd0, w_valid}, 32'd0);
    chk("t4_q_empty", 32'(exp_w.size()), 32'd0);

    // READY toggling
    do_reset();
    pc_model = 32'h0;
    for (int k = 0; k < 6; k++) begin
      READY = (k % 2 == 0);
      if (READY) exp_q.push_back(pc_model);
      at_neg();
      chk("t5_pc", PC, pc_model);
      chk("t5_valid", {31'd0, ID_VALID}, 32'(k % 2));
      if (READY) pc_model = pc_model + 32'd4;
      tick();
    end
    READY = 1'b0;
    at_neg();
    chk("t5_pc_end", PC, 32'hC);
    chk("t5_drained", {31'd0, ID_VALID}, 32'd0);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a full queue
    do_reset();
    READY = 1'b1;
    DECODE_STALL = 1'b1;
    tick();
    tick();
    #1;
    chk("t6_full", {31'd0, STALL}, 32'd1);
    chk("t6_pc_full", PC, 32'h8);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("t6_valid", {31'd0, ID_VALID}, 32'd0);
    chk("t6_stall", {31'd0, STALL}, 32'd0);
    chk("t6_pc", PC, 32'h0);
    chk("t6_id_instr", ID_INSTRUCTION, 32'h0000_0013);
    chk("t6_id_pc", ID_PC, 32'h0);
    tick();
    READY = 1'b0;
    DECODE_STALL = 1'b0;
    RESET_N = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the RISC-V pipeline, directly upstream of the instruction cache.
- Owns the program counter and presents it to the cache, then captures each returned instruction into a small fetch queue.
- Hands {PC, instruction} pairs to decode through a valid/stall handshake.
- Applies branch/jump redirects from execute, flushing all wrong-path fetches.

Parameters:
HIGH, 1'b1, logic-high constant
LOW, 1'b0, logic-low constant
RESET_VECTOR, 32'h0000_0000, first PC fetched after reset
QUEUE_DEPTH, 2, fetch-queue entries; power of two, at least 2
NOP_INSTRUCTION, 32'h0000_0013, value driven on ID_INSTRUCTION when the queue is empty (ADDI x0,x0,0)

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
PC  output  32  fetch address to instruction cache
INSTRUCTION_CACHE_STALL  output  1  holds the cache; high when the queue is full
INSTRUCTION  input  32  cache data for the current PC
INSTRUCTION_CACHE_READY  input  1  INSTRUCTION is valid for the current PC this cycle
BRANCH_TAKEN  input  1  redirect request from execute (single-cycle pulse)
BRANCH_TARGET  input  32  redirect address
DECODE_STALL  input  1  decode cannot accept this cycle
ID_VALID  output  1  queue head is valid
ID_PC  output  32  PC of queue head
ID_INSTRUCTION  output  32  instruction of queue head; NOP_INSTRUCTION when empty

Behaviour:
- Reset (RESET_N=0, asynchronous, any cycle including mid-fetch or mid-redirect):
  - PC=RESET_VECTOR; queue count=0; read/write pointers=0.
  - Outputs: ID_VALID=0, ID_PC=0, ID_INSTRUCTION=NOP_INSTRUCTION, INSTRUCTION_CACHE_STALL=0.
- Derived signals:
  - full = (count==QUEUE_DEPTH); empty = (count==0).
  - INSTRUCTION_CACHE_STALL = full, decoded from registered count only (no combinational path from inputs).
  - ID_VALID = !empty; ID_PC/ID_INSTRUCTION = head entry, combinationally from queue storage.
- Events per cycle:
  - push = INSTRUCTION_CACHE_READY && !full && !BRANCH_TAKEN.
  - pop = ID_VALID && !DECODE_STALL && !BRANCH_TAKEN.
- Push: write {PC, INSTRUCTION} at the write pointer; write pointer +1; PC <= PC+4.
  - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Pop: read pointer +1.
- Pointers wrap modulo QUEUE_DEPTH.
- Count update:
  - push and pop in the same cycle: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full:
  - No push, and PC holds. The cache sees STALL high and must hold READY/INSTRUCTION semantics for the same PC.
  - A pop while full frees a slot for the next cycle only; no same-cycle bypass.
- Empty: ID_VALID=0 regardless of cache data. There is no cache-to-decode bypass, so fetch-to-decode latency is 1 cycle minimum.
- Redirect (BRANCH_TAKEN=1) has absolute priority:
  - PC <= {BRANCH_TARGET[31:2], 2'b00}.
  - count <= 0; pointers <= 0.
  - Any push or pop in that cycle is suppressed.
  - Next cycle: ID_VALID=0, STALL=0.
  - A READY in the redirect cycle is discarded.
- Throughput: with READY=1 and DECODE_STALL=0 continuously, steady state is one instruction per cycle at count=1.
- INSTRUCTION_CACHE_READY=0: PC holds, queue drains normally.
- No state machine beyond the queue. Control is fully described by count, pointers and PC.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32, RESET_VECTOR default, NOP_INSTRUCTION, PC_INCREMENT=4.
  - Fetch-entry struct {pc[31:0], instruction[31:0]}.
- Sub-module fetch_queue: parameterised synchronous FIFO.
  - Entries are fetch entries.
  - Interface: push, pop, flush, full, empty, head.
  - The top level instantiates it and owns PC and redirect logic.

Test Plan:
1. Reset release with READY=1, DECODE_STALL=0 -> PC sequence 0,4,8,...; ID_VALID rises 1 cycle after the first READY; ID_PC=0 with ID_INSTRUCTION matching the cache word for address 0.
2. DECODE_STALL=1 for 5 cycles with READY=1 -> 2 pushes, then STALL=1 and PC held at 8; release stall -> entries PC 0,4 delivered in order and STALL drops the cycle after the first pop.
3. BRANCH_TAKEN with target 32'h0000_0102 while queue holds 2 entries -> next cycle ID_VALID=0, PC=32'h0000_0100; the next delivered ID_PC is 0x100; no 0x0/0x4 entries appear.
4. RESET_VECTOR=32'hFFFF_FFF8, READY=1 -> PC 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; ID_PC sequence matches.
5. READY toggling 1,0,1,0 with DECODE_STALL=0 -> PC advances only on READY cycles; no duplicate or skipped ID_PC.
6. RESET_N asserted mid-stream with queue full -> outputs immediately return to reset values (ID_VALID=0, STALL=0, PC=RESET_VECTOR) without waiting for a clock edge.
